subtractor_8b: RTL and testbench

Two's-complement 8-bit subtractor computing `a - b` modulo 256. It provides a zero-latency combinational difference port and a one-cycle registered result with borrow, signed-overflow, and zero flags plus a valid strobe. It serves as the arithmetic leaf used by the traffic-light timer/counter datapath wherever a down-count or interval difference is needed.

---
 rtl/sub_pkg.sv | 14 +
 rtl/full_subtractor.sv | 12 +
 rtl/subtractor_8b.sv | 67 ++++++
 tb/tb_subtractor_8b.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared width constant and result types for the 8-bit subtractor.
package sub_pkg;
  localparam int SUB_W = 8;

  typedef logic [SUB_W-1:0] sub_word_t;

  // Registered result bundle: difference plus status flags.
  typedef struct packed {
    sub_word_t diff;
    logic      borrow;
    logic      ovf;
    logic      zero;
  } sub_res_t;
endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a, or a == b and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/subtractor_8b.sv
// 8-bit ripple subtractor: combinational difference plus a one-cycle
// registered result with borrow / signed-overflow / zero flags.
module subtractor_8b
  import sub_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUB_W-1:0] a,
  input  logic [SUB_W-1:0] b,
  input  logic             in_valid,
  output logic [SUB_W-1:0] diff,
  output logic [SUB_W-1:0] diff_q,
  output logic             borrow_q,
  output logic             ovf_q,
  output logic             zero_q,
  output logic             out_valid
);
  localparam int STAGES = 1;

  logic [SUB_W:0] bchain;
  sub_res_t       res_c;
  sub_res_t       res_q;
  logic [STAGES:0] vld_pipe;

  assign bchain[0] = 1'b0;

  // Borrow ripples LSB to MSB through one cell per bit.
  for (genvar i = 0; i < SUB_W; i++) begin : g_fs
    full_subtractor u_fs (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bchain[i]),
      .d    (diff[i]),
      .bout (bchain[i+1])
    );
  end

  // Flags derived from the ripple result; overflow when operand signs
  // differ and the result sign departs from the minuend's.
  always_comb begin
    res_c.diff   = diff;
    res_c.borrow = bchain[SUB_W];
    res_c.ovf    = (a[SUB_W-1] ^ b[SUB_W-1]) & (diff[SUB_W-1] ^ a[SUB_W-1]);
    res_c.zero   = (diff == '0);
  end

  // Result bank loads only on in_valid; reset clears everything, so
  // zero_q reads 0 in reset even though diff_q is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        res_q <= '0;
    else if (in_valid) res_q <= res_c;
  end

  assign vld_pipe[0] = in_valid;

  // Valid strobe trails in_valid by the register latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_pipe[STAGES:1] <= '0;
    else        vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
  end

  assign diff_q    = res_q.diff;
  assign borrow_q  = res_q.borrow;
  assign ovf_q     = res_q.ovf;
  assign zero_q    = res_q.zero;
  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_subtractor_8b.sv
// Scoreboard bench for subtractor_8b: stimulus pushes expected results,
// a negedge monitor pops them when out_valid is seen and checks holds.
module tb_subtractor_8b;
  typedef struct packed {
    logic [7:0] d;
    logic       br;
    logic       ov;
    logic       z;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [7:0] diff, diff_q;
  logic       borrow_q, ovf_q, zero_q, out_valid;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t held = '0;
  logic exp_ov;

  subtractor_8b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .diff      (diff),
    .diff_q    (diff_q),
    .borrow_q  (borrow_q),
    .ovf_q     (ovf_q),
    .zero_q    (zero_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference using integer arithmetic, independent of the ripple form.
  function automatic exp_t mdl(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int   sd;
    sd   = int'($signed(x)) - int'($signed(y));
    e.d  = 8'((int'(x) - int'(y) + 256) % 256);
    e.br = (int'(x) < int'(y));
    e.ov = (sd > 127) || (sd < -128);
    e.z  = (x == y);
    return e;
  endfunction

  // Drive one operation just after a rising edge, then check diff.
  task automatic drive(input logic [7:0] ia, input logic [7:0] ib,
                       input logic v, input exp_t e);
    @(posedge clk);
    #1;
    a = ia;
    b = ib;
    in_valid = v;
    if (v) q.push_back(e);
    #3;
    chk("diff", diff, e.d);
  endtask

  // Expected out_valid: in_valid as sampled at each edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_ov <= 1'b0;
    else        exp_ov <= in_valid;
  end

  // Monitor: pop on out_valid, otherwise the last result must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        held = '0;
        chk("rst out_valid", out_valid, 0);
        chk("rst diff_q", diff_q, 0);
        chk("rst borrow_q", borrow_q, 0);
        chk("rst ovf_q", ovf_q, 0);
        chk("rst zero_q", zero_q, 0);
      end else begin
        chk("out_valid", out_valid, exp_ov);
        if (out_valid) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: out_valid with no expected entry (t=%0t)", $time);
          end else begin
            held = q.pop_front();
          end
        end
        chk("diff_q", diff_q, held.d);
        chk("borrow_q", borrow_q, held.br);
        chk("ovf_q", ovf_q, held.ov);
        chk("zero_q", zero_q, held.z);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Hand-computed corner vectors.
    drive(8'h00, 8'h01, 1'b1, '{d: 8'hFF, br: 1'b1, ov: 1'b0, z: 1'b0});
    drive(8'h80, 8'h01, 1'b1, '{d: 8'h7F, br: 1'b0, ov: 1'b1, z: 1'b0});
    drive(8'h7F, 8'hFF, 1'b1, '{d: 8'h80, br: 1'b1, ov: 1'b1, z: 1'b0});
    drive(8'h10, 8'h20, 1'b1, '{d: 8'hF0, br: 1'b1, ov: 1'b0, z: 1'b0});
    drive(8'h05, 8'h05, 1'b1, '{d: 8'h00, br: 1'b0, ov: 1'b0, z: 1'b1});
    // in_valid low: registered outputs must hold the 0x05-0x05 result.
    drive(8'h33, 8'h11, 1'b0, '{d: 8'h22, br: 1'b0, ov: 1'b0, z: 1'b0});
    drive(8'h33, 8'h11, 1'b0, '{d: 8'h22, br: 1'b0, ov: 1'b0, z: 1'b0});

    // Async reset between edges clears registers at once; diff keeps tracking.
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async diff_q", diff_q, 0);
    chk("async borrow_q", borrow_q, 0);
    chk("async ovf_q", ovf_q, 0);
    chk("async zero_q", zero_q, 0);
    chk("async out_valid", out_valid, 0);
    chk("async diff", diff, 8'h22);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First capture after release.
    drive(8'h40, 8'h41, 1'b1, '{d: 8'hFF, br: 1'b1, ov: 1'b0, z: 1'b0});
    drive(8'h81, 8'h7F, 1'b1, '{d: 8'h02, br: 1'b0, ov: 1'b1, z: 1'b0});

    // Full sweep, back-to-back captures: a = i[7:0], b = i[15:8].
    for (int i = 0; i < 65536; i++) begin
      logic [15:0] iv;
      iv = 16'(i);
      drive(iv[7:0], iv[15:8], 1'b1, mdl(iv[7:0], iv[15:8]));
    end

    drive(8'h00, 8'h00, 1'b0, '{d: 8'h00, br: 1'b0, ov: 1'b0, z: 1'b1});
    repeat (2) @(posedge clk);
    #2;
    chk("sb drained", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
